rr_arb4_sel: RTL and testbench



---
 rtl/rr_arb4_sel.sv | 165 ++++++++++++++++
 tb/tb_rr_arb4_sel.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rr_arb4_sel.sv
// rr_arb4_sel: four-requester round-robin packet arbiter that drives the select
// of a downstream 4:1 data mux plus the per-channel handshakes.
// A grant is locked for a whole packet and released on the accepted last beat.
// The releasing channel then drops to lowest priority.
// Optional forced release of a stalled lock: define ARB_TIMEOUT_EN.
module rr_arb4_sel #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       out_valid,
    output logic [3:0] in_ready,
    output logic       busy,
    output logic       timeout
);

    // Reject hold limits the counter cannot represent before anything is built.
    if ((MAX_HOLD < 2) || (MAX_HOLD > 65535) ||
        ((64'd1 << CNT_W) <= 64'(MAX_HOLD))) begin : gBadParams
        $error("rr_arb4_sel: MAX_HOLD must be 2..65535 and below 2**CNT_W");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] ptr_q,   ptr_d;
    logic       busy_q,  busy_d;

    logic [1:0] idleWinner;
    logic [1:0] releaseWinner;
    logic       beatAccept;
    logic       lastAccept;
    logic       holdExpire;

    // Search order is base+1, base+2, base+3, base; the earliest requester wins.
    // Iterating from the far end lets the closest hit overwrite the result.
    function automatic logic [1:0] pickWinner(input logic [1:0] base,
                                              input logic [3:0] reqVec);
        logic [1:0] idx;
        pickWinner = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (reqVec[idx]) begin
                pickWinner = idx;
            end
        end
    endfunction

    // From IDLE the search starts after the last released channel.
    assign idleWinner = pickWinner(ptr_q, req);
    // On release the releasing channel becomes the new pointer, which makes it lowest priority.
    assign releaseWinner = pickWinner(sel_q, req);

    // Handshakes come straight from the registered grant; grant is zero in IDLE.
    assign out_valid  = |(grant_q & req);
    assign in_ready   = grant_q & {4{out_ready}};
    assign beatAccept = (state_q == LOCKED) && out_valid && out_ready;
    assign lastAccept = beatAccept && last[sel_q];

    assign sel   = sel_q;
    assign grant = grant_q;
    assign busy  = busy_q;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
    logic             timeout_q, timeout_d;

    // Expiry is the stalled cycle that would carry the counter up to MAX_HOLD.
    // An accepted beat never expires, so a last on that cycle is a normal release.
    assign holdExpire = (state_q == LOCKED) && !beatAccept &&
                        (holdCnt_q == CNT_W'(MAX_HOLD - 1));

    // Count stalled LOCKED cycles; any accepted beat, release or fresh lock restarts it.
    always_comb begin
        holdCnt_d = '0;
        timeout_d = holdExpire;
        if ((state_q == LOCKED) && !beatAccept && !holdExpire) begin
            holdCnt_d = holdCnt_q + CNT_W'(1);
        end
    end

    // Hold counter and the one-cycle timeout pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            holdCnt_q <= holdCnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign holdExpire = 1'b0;
    assign timeout    = 1'b0;
`endif

    // Next-state: lock onto a winner from IDLE, or on release hand over with no idle bubble.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = LOCKED;
                    grant_d = 4'b0001 << idleWinner;
                    sel_d   = idleWinner;
                    busy_d  = 1'b1;
                end
            end
            LOCKED: begin
                if (lastAccept || holdExpire) begin
                    ptr_d = sel_q;
                    if (|req) begin
                        grant_d = 4'b0001 << releaseWinner;
                        sel_d   = releaseWinner;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Arbiter state registers; reset abandons any packet in flight.
    // The pointer resets to 3 so channel 0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b11;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_rr_arb4_sel.sv
// tb_rr_arb4_sel: directed checks of rr_arb4_sel in its default build.
// Each step drives inputs just after a rising edge, then compares the packed outputs
// {sel, grant, out_valid, in_ready, busy, timeout} with hand-computed values.
module tb_rr_arb4_sel;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] last;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       out_valid;
    logic [3:0] in_ready;
    logic       busy;
    logic       timeout;

    int compared   = 0;
    int mismatched = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    rr_arb4_sel dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .timeout   (timeout)
    );

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the requester and consumer inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic o);
        req       = r;
        last      = l;
        out_ready = o;
        #1;
    endtask

    // Compare every output at once against the expected values.
    task automatic checkOutput(input string tag, input logic [1:0] eSel, input logic [3:0] eGrant,
                               input logic eValid, input logic [3:0] eInReady, input logic eBusy);
        logic [12:0] observed;
        logic [12:0] expected;
        observed = {sel, grant, out_valid, in_ready, busy, timeout};
        expected = {eSel, eGrant, eValid, eInReady, eBusy, 1'b0};
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed sel/grant/valid/in_ready/busy/timeout=%b expected=%b",
                   tag, observed, expected);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        reset     = 1'b1;
        req       = 4'b0000;
        last      = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset-values", 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // All four requesting single-beat packets: one grant per cycle in order 0,1,2,3,0.
        reset = 1'b0;
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        checkOutput("idle-before-grant", 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rotate-%0d", i), i[1:0], 4'b0001 << i[1:0], 1'b1,
                        4'b0001 << i[1:0], 1'b1);
            if (i != 4) tick();
        end

        // Channel 0 sends a 3-beat packet while channel 2 waits, then channel 2 takes over.
        applyStimulus(4'b0101, 4'b0000, 1'b1);
        checkOutput("pkt-beat1", 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1);
        tick();
        checkOutput("pkt-beat2", 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1);
        tick();
        applyStimulus(4'b0101, 4'b0001, 1'b1);
        checkOutput("pkt-beat3", 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1);
        tick();
        checkOutput("pkt-next-ch2", 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1);

        // Release channel 2; the search starts at 3, so channel 1 wins over channel 2.
        applyStimulus(4'b0110, 4'b0100, 1'b1);
        tick();
        checkOutput("to-ch1", 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1);

        // Consumer stalls for 5 cycles: the lock is frozen and no in_ready goes out.
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall-%0d", i), 2'd1, 4'b0010, 1'b1, 4'b0000, 1'b1);
            tick();
        end
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        checkOutput("stall-release", 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1);
        tick();
        checkOutput("single-regrant", 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1);

        // Release channel 1 with channel 3 waiting, so channel 3 locks.
        applyStimulus(4'b1010, 4'b0010, 1'b1);
        tick();
        checkOutput("to-ch3", 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1);

        // Channel 3 drops req while channel 0 asks: the lock holds, and last without req is ignored.
        applyStimulus(4'b0001, 4'b1000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ch3-drop-%0d", i), 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1);
            tick();
        end
        applyStimulus(4'b1001, 4'b1000, 1'b1);
        checkOutput("ch3-last", 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1);
        tick();
        checkOutput("after-ch3", 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1);

        // Move the lock to channel 2, start a packet, then reset it mid-packet.
        applyStimulus(4'b0101, 4'b0001, 1'b1);
        tick();
        checkOutput("to-ch2", 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1);
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        tick();
        checkOutput("ch2-mid", 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("async-reset", 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b0110, 4'b0000, 1'b1);
        tick();
        checkOutput("reset-held", 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Leave reset with no request, then request 0110: channel 0 priority means channel 1 wins.
        reset = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("idle-noreq", 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("idle-hold", 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b0110, 4'b0000, 1'b1);
        checkOutput("idle-pre-grant", 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("post-reset-ch1", 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
